// File: rtl/trace_pkg.sv
// Shared types for the retirement trace capture block: FSM states, halt causes
// and the stored trace entry layout.
package trace_pkg;

  localparam int unsigned TRACE_XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HALTED  = 2'd2
  } trace_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_PC_HIT = 2'd1,
    CAUSE_FULL   = 2'd2,
    CAUSE_LIMIT  = 2'd3
  } trace_cause_e;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [31:0]           inst;
    logic [4:0]            rd;
    logic                  we;
    logic [TRACE_XLEN-1:0] wdata;
  } trace_entry_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/trace_capture_if.sv
// Retire-side input bundle and drain-side handshake of the trace capture block.
interface trace_capture_if #(
  parameter int unsigned XLEN = 32
);
  logic            ret_valid;
  logic [XLEN-1:0] ret_pc;
  logic [31:0]     ret_inst;
  logic [4:0]      ret_rd;
  logic            ret_we;
  logic [XLEN-1:0] ret_wdata;

  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [31:0]     rd_inst;
  logic [4:0]      rd_rd;
  logic            rd_we;
  logic [XLEN-1:0] rd_wdata;

  modport master (
    output ret_valid, ret_pc, ret_inst, ret_rd, ret_we, ret_wdata, rd_ready,
    input  rd_valid, rd_pc, rd_inst, rd_rd, rd_we, rd_wdata
  );

  modport slave (
    input  ret_valid, ret_pc, ret_inst, ret_rd, ret_we, ret_wdata, rd_ready,
    output rd_valid, rd_pc, rd_inst, rd_rd, rd_we, rd_wdata
  );
endinterface

// File: rtl/trace_ring.sv
// Circular buffer of trace entries; in RING mode a push into a full buffer
// replaces the oldest entry, otherwise it is dropped.
module trace_ring
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter bit          RING  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  trace_entry_t           wr_entry,
  output trace_entry_t           rd_entry,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  trace_entry_t  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   count_q;
  logic          do_pop;
  logic          room;
  logic          do_write;
  logic          ovw;

  assign full     = (count_q == FULL_CNT);
  assign do_pop   = pop && (count_q != '0);
  // A same-cycle pop frees a slot, so a push then never needs to overwrite.
  assign room     = !full || do_pop;
  assign do_write = push && (room || RING);
  assign ovw      = push && !room && RING;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (do_write) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop || ovw) begin
        rptr <= rptr + 1'b1;
      end
      if (do_write && !ovw && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_write) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign rd_entry = mem[rptr];
  assign count    = count_q;

endmodule

// File: rtl/trace_capture.sv
// Captures retired instructions into a trace buffer until a stop PC, a full
// buffer or the cycle watchdog halts capture, then lets a consumer drain it.
module trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH       = 16,
  parameter logic [XLEN-1:0] STOP_PC     = XLEN'(32'h0000_0400),
  parameter int unsigned     CYCLE_LIMIT = 1000,
  parameter bit              RING        = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  trace_capture_if.slave         bus,
  output logic [1:0]             state,
  output logic [1:0]             cause,
  output logic [$clog2(DEPTH):0] count,
  output logic [31:0]            cycles,
  output logic                   overflow
);

  localparam int unsigned CW         = $clog2(DEPTH) + 1;
  localparam logic [31:0] LIMIT_LAST = 32'(CYCLE_LIMIT - 1);

  trace_state_e state_q, state_d;
  trace_cause_e cause_q, cause_d;
  logic [31:0]  cycles_q, cycles_d;
  logic         overflow_q, overflow_d;

  logic         ring_clear;
  logic         ring_push;
  logic         ring_pop;
  logic         ring_full;
  logic [CW-1:0] ring_count;
  trace_entry_t wr_entry;
  trace_entry_t rd_entry;
  logic         rd_valid_c;

  always_comb begin
    wr_entry.pc    = TRACE_XLEN'(bus.ret_pc);
    wr_entry.inst  = bus.ret_inst;
    wr_entry.rd    = bus.ret_rd;
    wr_entry.we    = bus.ret_we;
    wr_entry.wdata = TRACE_XLEN'(bus.ret_wdata);
  end

  trace_ring #(
    .DEPTH (DEPTH),
    .RING  (RING)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .clear    (ring_clear),
    .push     (ring_push),
    .pop      (ring_pop),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry),
    .count    (ring_count),
    .full     (ring_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cause_q    <= CAUSE_NONE;
      cycles_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      cycles_q   <= cycles_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    cycles_d   = cycles_q;
    overflow_d = overflow_q;
    ring_clear = 1'b0;
    ring_push  = 1'b0;
    ring_pop   = 1'b0;
    rd_valid_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d    = ST_CAPTURE;
          cause_d    = CAUSE_NONE;
          cycles_d   = '0;
          overflow_d = 1'b0;
          ring_clear = 1'b1;
        end
      end

      ST_CAPTURE: begin
        cycles_d  = sat_inc32(cycles_q);
        ring_push = bus.ret_valid;
        if (bus.ret_valid && ring_full && RING) begin
          overflow_d = 1'b1;
        end
        // Checked in priority order: stop PC, then full buffer, then watchdog.
        if (bus.ret_valid && (bus.ret_pc == STOP_PC)) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_PC_HIT;
        end else if (bus.ret_valid && ring_full && !RING) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_FULL;
        end else if (cycles_q == LIMIT_LAST) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_LIMIT;
        end
      end

      ST_HALTED: begin
        rd_valid_c = (ring_count != '0);
        if (arm) begin
          state_d    = ST_CAPTURE;
          cause_d    = CAUSE_NONE;
          cycles_d   = '0;
          overflow_d = 1'b0;
          ring_clear = 1'b1;
        end else begin
          ring_pop = rd_valid_c && bus.rd_ready;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.rd_valid = rd_valid_c;
  assign bus.rd_pc    = XLEN'(rd_entry.pc);
  assign bus.rd_inst  = rd_entry.inst;
  assign bus.rd_rd    = rd_entry.rd;
  assign bus.rd_we    = rd_entry.we;
  assign bus.rd_wdata = XLEN'(rd_entry.wdata);

  assign state    = state_q;
  assign cause    = cause_q;
  assign count    = ring_count;
  assign cycles   = cycles_q;
  assign overflow = overflow_q;

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter XLEN, 32, width of PC and write-back data.
REQ-002 Parameter DEPTH, 16, trace entries; power of two, >=2.
REQ-003 Parameter STOP_PC, 32'h0000_0400, retire PC that ends capture.
REQ-004 Parameter CYCLE_LIMIT, 1000, watchdog cycles per capture; >=1.
REQ-005 Parameter RING, 0, 1 = overwrite oldest entry when full; 0 = halt when full.
REQ-006 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-007 Port rst  in  1  synchronous, active-high reset.
REQ-008 Port arm  in  1  start a capture; honoured only in IDLE or HALTED.
REQ-009 Port ret_valid  in  1  one instruction retires this cycle.
REQ-010 Port ret_pc  in  XLEN  PC of the retiring instruction.
REQ-011 Port ret_inst  in  32  instruction word.
REQ-012 Port ret_rd / ret_we / ret_wdata  in  5 / 1 / XLEN  destination register, write enable, write-back value.
REQ-013 Port rd_valid  out  1  a trace entry is presented.
REQ-014 Port rd_ready  in  1  consumer accepts the entry.
REQ-015 Port rd_pc / rd_inst / rd_rd / rd_we / rd_wdata  out  per REQ-010..012  oldest entry.
REQ-016 Port state  out  2  IDLE=0, CAPTURE=1, HALTED=2.
REQ-017 Port cause  out  2  NONE=0, PC_HIT=1, FULL=2, LIMIT=3.
REQ-018 Port count  out  $clog2(DEPTH)+1  valid entries held.
REQ-019 Port cycles  out  32  cycles spent in the current or last capture.
REQ-020 Port overflow  out  1  sticky; one or more entries overwritten in RING mode.

Function
REQ-021 IDLE: retires ignored; rd_valid=0; arm moves to CAPTURE next cycle and clears count, pointers, cycles, cause and overflow.
REQ-022 CAPTURE: cycles increments by 1 every cycle, saturating at 2^32-1.
REQ-023 CAPTURE with ret_valid and count<DEPTH: entry is written at the write pointer and count increments; the entry is visible on rd_* from the next cycle onward.
REQ-024 CAPTURE with ret_valid, count==DEPTH and RING=1: oldest entry is overwritten, read pointer advances, count stays DEPTH, overflow is set.
REQ-025 CAPTURE with ret_valid, count==DEPTH and RING=0: entry is dropped; next state is HALTED with cause FULL.
REQ-026 ret_valid with ret_pc==STOP_PC: entry is captured under REQ-023/024, then next state is HALTED with cause PC_HIT.
REQ-027 When cycles==CYCLE_LIMIT-1 in CAPTURE: next state is HALTED with cause LIMIT; a retire in that cycle is still captured.
REQ-028 Simultaneous stop conditions: cause priority is PC_HIT > FULL > LIMIT.
REQ-029 arm in CAPTURE is ignored.
REQ-030 HALTED: rd_valid = (count!=0); rd_* is driven combinationally from the read pointer.
REQ-031 HALTED: rd_valid && rd_ready pops one entry per cycle; the read pointer wraps modulo DEPTH.
REQ-032 HALTED: cause, cycles and overflow hold their values; retires are ignored.
REQ-033 arm in HALTED restarts capture per REQ-021 and discards undrained entries; arm has priority over a same-cycle pop.
REQ-034 rd_valid=0 outside HALTED; rd_ready is ignored there.

Reset
REQ-035 rst high at a clock edge forces: state=IDLE, cause=NONE, count=0, cycles=0, overflow=0, rd_valid=0, and pointers=0; it overrides all other inputs, including mid-capture.
REQ-036 Storage contents are not reset; rd_* is don't-care while rd_valid=0.

Structure
REQ-037 Shared package trace_pkg holds the state enum, the cause codes, and the trace entry struct (pc, inst, rd, we, wdata).
REQ-038 One sub-module, trace_ring: a circular buffer of DEPTH entries with push, pop, overwrite-on-full, count, and pointer wrap.

Verification
REQ-039 DEPTH=16, RING=0: arm, then 5 retires at PC 0x0..0x10, then a retire at 0x400 -> HALTED, cause=1, count=6; drain returns PCs 0x0,0x4,...,0x10,0x400 in order.
REQ-040 DEPTH=4, RING=0: 5 retires without a stop PC -> HALTED after the 5th retire, cause=2, count=4; the 5th entry is absent.
REQ-041 DEPTH=4, RING=1: 10 retires with PCs 0..36 step 4, then 0x400 -> cause=1, overflow=1, drain yields 28, 32, 36, 0x400.
REQ-042 CYCLE_LIMIT=8, no retires -> HALTED exactly 8 cycles after entering CAPTURE, cycles=8, cause=3, rd_valid=0.
REQ-043 rst asserted mid-capture with count=3 -> next cycle state=0, count=0, rd_valid=0; a later arm captures normally.
REQ-044 HALTED with count=2, rd_ready toggling 1,0,1 -> exactly 2 pops, the first on cycle 1 and the second on cycle 3; rd_valid then drops to 0.
